// File: rtl/nibble_seq_pkg.sv
// Shared types and constants for the nibble-serial add sequencer.
// Holds the FSM state encoding and the nibble width.
package nibble_seq_pkg;

  localparam int NIBBLE_W    = 4;
  localparam int DEF_NIBBLES = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_sequencer_adder.sv
// Combinational 4-bit ripple-carry adder built from four full adders.
// Ports: a, b (4-bit addends), ci (carry in), s (4-bit sum), co (carry out).
module nibble_adder
  import nibble_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co
);

  logic [NIBBLE_W:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i])
                  | (a[i] & c[i])
                  | (b[i] & c[i]);
  end

  assign co = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_add_sequencer.sv
// Adds two multi-nibble operands through one shared 4-bit adder, LSB
// nibble first, one nibble per clock, with a start/busy/done handshake.
// Ports: clk, clr (async active-low reset), start, a, b, cin in;
//        busy, done, sum, cout, ovf out (all registered).
module nibble_serial_add_sequencer
  import nibble_seq_pkg::*;
#(
  parameter int NIBBLES = DEF_NIBBLES
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        start,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                        cin,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                        cout,
  output logic                        ovf
);

  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    a_sh_q;
  logic [W-1:0]    b_sh_q;
  logic            carry_q;
  logic            a_msb_q;
  logic            b_msb_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            ovf_q;
  logic            busy_q;
  logic            done_q;

  logic [NIBBLE_W-1:0] nib;
  logic                nib_co;
  logic                accept;
  logic                in_run;

  nibble_adder u_add (
    .a  (a_sh_q[NIBBLE_W-1:0]),
    .b  (b_sh_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (nib),
    .co (nib_co)
  );

  assign in_run = (state_q == S_RUN);
  // start is only honoured outside RUN
  assign accept = start & ~in_run;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        accept: begin
          state_q <= S_RUN;
          busy_q  <= 1'b1;
          idx_q   <= '0;
          a_sh_q  <= a;
          b_sh_q  <= b;
          carry_q <= cin;
          a_msb_q <= a[W-1];
          b_msb_q <= b[W-1];
          sum_q   <= '0;
          cout_q  <= 1'b0;
          ovf_q   <= 1'b0;
        end
        in_run: begin
          // result nibbles enter at the top and walk down
          sum_q   <= {nib, sum_q[W-1:NIBBLE_W]};
          carry_q <= nib_co;
          a_sh_q  <= {{NIBBLE_W{1'b0}},
                      a_sh_q[W-1:NIBBLE_W]};
          b_sh_q  <= {{NIBBLE_W{1'b0}},
                      b_sh_q[W-1:NIBBLE_W]};
          idx_q   <= idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= nib_co;
            // nib[3] becomes the final sum MSB
            ovf_q   <= (a_msb_q == b_msb_q)
                     & (nib[NIBBLE_W-1] != a_msb_q);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
